// File: rtl/xbar_pkg.sv
// xbar_pkg: shared arbitration modes and one-hot/index helpers for the crossbar.
package xbar_pkg;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  function automatic logic [31:0] idx2oh(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction
  function automatic logic [31:0] oh2idx(input logic [31:0] oh);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = 32'(i);
    return r;
  endfunction
endpackage

// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: request/handshake bundle between sources, arbiter and master mux.
interface stream_rr_arbiter_if #(parameter int N = 5, parameter int W = $clog2(N)) ();
  logic [N-1:0] s_valid_i;
  logic [N-1:0] s_last_i;
  logic         m_ready_i;
  logic [N-1:0] grant_o;
  logic         m_valid_o;
  logic         m_last_o;
  logic [W-1:0] m_id_o;
  logic         busy_o;
  modport slave (input s_valid_i, s_last_i, m_ready_i, output grant_o, m_valid_o, m_last_o, m_id_o, busy_o);
  modport master (output s_valid_i, s_last_i, m_ready_i, input grant_o, m_valid_o, m_last_o, m_id_o, busy_o);
endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// rr_pick: combinational winner select, rotating from ptr_i or fixed lowest-index first.
module rr_pick import xbar_pkg::*; #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] ptr_i,
  input  logic         mode_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [N-1:0] req;
  int p;
  always_comb begin
    req = req_i & ~mask_i;
    onehot_o = '0;
    p = 0;
    for (int k = 0; k < N; k++) begin
      p = mode_i ? k : int'(ptr_i) + k;
      p = p >= N ? p - N : p;
      if (onehot_o == '0 && req[p]) onehot_o = N'(idx2oh(32'(p)));
    end
  end
  assign idx_o = W'(oh2idx(32'(onehot_o)));
  assign any_o = |req;
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locking source arbiter for one crossbar master port.
module stream_rr_arbiter import xbar_pkg::*; #(
  parameter int S_DATA_COUNT  = 5,
  parameter int T_ID___WIDTH  = $clog2(S_DATA_COUNT),
  parameter int ARB_MODE      = ARB_RR,
  parameter int MAX_PKT_BEATS = 0
) (
  input logic clk,
  input logic rst,
  stream_rr_arbiter_if.slave bus
);
  localparam int N = S_DATA_COUNT;
  localparam int W = T_ID___WIDTH;
  localparam int BW = MAX_PKT_BEATS > 0 ? $clog2(MAX_PKT_BEATS + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [W-1:0]  id_q, id_d, ptr_q, ptr_d, nxt_id, pick_ptr, pick_idx;
  logic [N-1:0]  grant_q, grant_d, pick_mask, pick_oh;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          locked, beat, max_hit, rel, pick_any;
  assign locked = state_q == LOCKED;
  assign beat = locked & bus.s_valid_i[id_q] & bus.m_ready_i;
  assign max_hit = int'(cnt_q) + 1 == MAX_PKT_BEATS;
  assign rel = beat & (bus.s_last_i[id_q] | max_hit);
  assign nxt_id = id_q == W'(N - 1) ? '0 : id_q + 1'b1;
  // On release the finishing source is masked so another requester can take over without a bubble.
  assign pick_mask = rel ? N'(idx2oh(32'(id_q))) : '0;
  assign pick_ptr = rel ? nxt_id : ptr_q;
  rr_pick #(.N(N), .W(W)) u_pick (
    .req_i    (bus.s_valid_i),
    .mask_i   (pick_mask),
    .ptr_i    (pick_ptr),
    .mode_i   (ARB_MODE == ARB_FIXED),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (!locked || rel) begin
      ptr_d = pick_ptr;
      state_d = pick_any ? LOCKED : IDLE;
      grant_d = pick_oh;
      id_d = pick_any ? pick_idx : id_q;
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q <= '0;
      grant_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.grant_o = grant_q;
  assign bus.busy_o = locked;
  assign bus.m_id_o = id_q;
  assign bus.m_valid_o = locked & bus.s_valid_i[id_q];
  assign bus.m_last_o = locked & bus.s_last_i[id_q];
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed scenarios on a round-robin and a fixed/max-beat instance, checked against a packet-level model.
module tb_stream_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] valid = '0;
  logic [4:0] last = '0;
  logic ready = 1'b0;
  logic chk_en = 1'b0;
  int tests = 0;
  int fails = 0;
  int own [2];
  int mptr [2];
  int beats [2];
  logic [4:0] dg;
  logic db, dv, dl;
  logic [2:0] di;
  int eo;
  always #5 clk = ~clk;
  stream_rr_arbiter_if #(.N(5)) ia ();
  stream_rr_arbiter_if #(.N(5)) ib ();
  assign ia.s_valid_i = valid;
  assign ia.s_last_i = last;
  assign ia.m_ready_i = ready;
  assign ib.s_valid_i = valid;
  assign ib.s_last_i = last;
  assign ib.m_ready_i = ready;
  stream_rr_arbiter #(.S_DATA_COUNT(5), .ARB_MODE(0), .MAX_PKT_BEATS(0)) u_rr (.clk(clk), .rst(rst), .bus(ia));
  stream_rr_arbiter #(.S_DATA_COUNT(5), .ARB_MODE(1), .MAX_PKT_BEATS(2)) u_fx (.clk(clk), .rst(rst), .bus(ib));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Winner over requests v, scanning from p (or from 0 when fixed), skipping source excl.
  function automatic int pick(input logic [4:0] v, input int p, input int excl, input bit fixed);
    for (int k = 0; k < 5; k++) begin
      int i;
      i = fixed ? k : (p + k) % 5;
      if (i != excl && v[i]) return i;
    end
    return -1;
  endfunction
  initial for (int j = 0; j < 2; j++) begin
    own[j] = -1;
    mptr[j] = 0;
    beats[j] = 0;
  end
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        own[j] = -1;
        mptr[j] = 0;
        beats[j] = 0;
      end else if (own[j] < 0) begin
        own[j] = pick(valid, mptr[j], -1, j == 1);
        beats[j] = 0;
      end else if (valid[own[j]] && ready) begin
        beats[j]++;
        if (last[own[j]] || (j == 1 && beats[j] == 2)) begin
          mptr[j] = (own[j] + 1) % 5;
          own[j] = pick(valid, mptr[j], own[j], j == 1);
          beats[j] = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 2; j++) begin
        dg = j == 1 ? ib.grant_o : ia.grant_o;
        db = j == 1 ? ib.busy_o : ia.busy_o;
        dv = j == 1 ? ib.m_valid_o : ia.m_valid_o;
        dl = j == 1 ? ib.m_last_o : ia.m_last_o;
        di = j == 1 ? ib.m_id_o : ia.m_id_o;
        eo = own[j];
        check($sformatf("model_grant[%0d]", j), 32'(dg), eo >= 0 ? 32'd1 << eo : 32'd0);
        check($sformatf("model_busy[%0d]", j), 32'(db), 32'(eo >= 0));
        check($sformatf("model_mvalid[%0d]", j), 32'(dv), eo >= 0 ? 32'(valid[eo]) : 32'd0);
        check($sformatf("model_mlast[%0d]", j), 32'(dl), eo >= 0 ? 32'(last[eo]) : 32'd0);
        if (eo >= 0) check($sformatf("model_id[%0d]", j), 32'(di), 32'(eo));
      end
    end
  end
  task automatic step(input logic [4:0] v, input logic [4:0] l, input logic r, input logic rs);
    @(posedge clk);
    #1;
    valid = v;
    last = l;
    ready = r;
    rst = rs;
    @(negedge clk);
  endtask
  initial begin
    step(5'b11111, 5'b00000, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(5'b11111, 5'b00000, 1'b0, 1'b1);
    check("reset_grant", 32'(ia.grant_o), 32'h0);
    check("reset_busy", 32'(ia.busy_o), 32'h0);
    check("reset_id", 32'(ia.m_id_o), 32'h0);
    step(5'b11111, 5'b11111, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(5'b11111, 5'b11111, 1'b1, 1'b0);
      check($sformatf("rr_id_%0d", i), 32'(ia.m_id_o), 32'(i % 5));
      check($sformatf("rr_busy_%0d", i), 32'(ia.busy_o), 32'h1);
    end
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    step(5'b00100, 5'b00000, 1'b1, 1'b0);
    step(5'b10101, 5'b00000, 1'b0, 1'b0);
    check("lock_grant_a", 32'(ia.grant_o), 32'h04);
    step(5'b10101, 5'b00000, 1'b1, 1'b0);
    check("lock_grant_b", 32'(ia.grant_o), 32'h04);
    step(5'b10101, 5'b00000, 1'b0, 1'b0);
    check("lock_grant_c", 32'(ia.grant_o), 32'h04);
    step(5'b10101, 5'b00000, 1'b1, 1'b0);
    check("lock_grant_d", 32'(ia.grant_o), 32'h04);
    step(5'b10101, 5'b00000, 1'b1, 1'b0);
    check("lock_grant_e", 32'(ia.grant_o), 32'h04);
    step(5'b10101, 5'b00100, 1'b0, 1'b0);
    check("lock_grant_f", 32'(ia.grant_o), 32'h04);
    step(5'b10101, 5'b00100, 1'b1, 1'b0);
    check("lock_grant_g", 32'(ia.grant_o), 32'h04);
    step(5'b10101, 5'b00000, 1'b0, 1'b0);
    check("lock_next_grant", 32'(ia.grant_o), 32'h10);
    check("lock_next_id", 32'(ia.m_id_o), 32'h4);
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    step(5'b00010, 5'b00010, 1'b0, 1'b0);
    step(5'b00010, 5'b00010, 1'b0, 1'b0);
    check("bp_grant_a", 32'(ia.grant_o), 32'h02);
    step(5'b00010, 5'b00010, 1'b0, 1'b0);
    check("bp_grant_b", 32'(ia.grant_o), 32'h02);
    step(5'b00010, 5'b00010, 1'b1, 1'b0);
    check("bp_grant_c", 32'(ia.grant_o), 32'h02);
    step(5'b00000, 5'b00000, 1'b0, 1'b0);
    check("bp_release_grant", 32'(ia.grant_o), 32'h0);
    check("bp_release_busy", 32'(ia.busy_o), 32'h0);
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    step(5'b01010, 5'b00000, 1'b1, 1'b0);
    step(5'b00010, 5'b00000, 1'b1, 1'b0);
    check("fx_first_grant", 32'(ib.grant_o), 32'h02);
    step(5'b00010, 5'b00000, 1'b1, 1'b0);
    check("fx_beat2_grant", 32'(ib.grant_o), 32'h02);
    step(5'b00010, 5'b00000, 1'b1, 1'b0);
    check("fx_idle_gap", 32'(ib.grant_o), 32'h0);
    step(5'b00010, 5'b00000, 1'b1, 1'b0);
    check("fx_regrant", 32'(ib.grant_o), 32'h02);
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    step(5'b01000, 5'b00000, 1'b1, 1'b0);
    step(5'b01000, 5'b00000, 1'b1, 1'b0);
    check("rstmid_grant_a", 32'(ia.grant_o), 32'h08);
    step(5'b11111, 5'b00000, 1'b1, 1'b1);
    check("rstmid_grant_b", 32'(ia.grant_o), 32'h08);
    step(5'b11111, 5'b00000, 1'b1, 1'b0);
    check("rstmid_dropped", 32'(ia.grant_o), 32'h0);
    check("rstmid_busy", 32'(ia.busy_o), 32'h0);
    step(5'b11111, 5'b00000, 1'b1, 1'b0);
    check("rstmid_repick", 32'(ia.grant_o), 32'h01);
    step(5'b00000, 5'b00000, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
